// File: rtl/y86_seq_fde_if.sv
// Bus interface for the Y86-64 SEQ fetch/decode/execute front end.
// The master (a testbench or the surrounding core) drives these signals:
//   PC, imem_we, imem_addr, imem_wdata, wb_en, valM.
// The slave (y86_seq_fde) drives these signals:
//   icode, ifun, rA, rB, valC, valP, instr_valid, valA, valB, valE, cnd, ZF, SF, OF.
interface y86_seq_fde_if;
    logic [63:0] PC;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [7:0]  imem_wdata;
    logic        wb_en;
    logic [63:0] valM;

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valE;
    logic        cnd;
    logic        ZF;
    logic        SF;
    logic        OF;

    modport master (
        output PC, imem_we, imem_addr, imem_wdata, wb_en, valM,
        input  icode, ifun, rA, rB, valC, valP, instr_valid,
               valA, valB, valE, cnd, ZF, SF, OF
    );

    modport slave (
        input  PC, imem_we, imem_addr, imem_wdata, wb_en, valM,
        output icode, ifun, rA, rB, valC, valP, instr_valid,
               valA, valB, valE, cnd, ZF, SF, OF
    );
endinterface

// File: rtl/y86_seq_fde.sv
// Y86-64 SEQ front end: fetch, decode and execute for the instruction at PC.
// It holds the byte-wide instruction memory, the 15-entry register file and
// the condition codes.
// Ports:
//   Clk   rising-edge clock for every state update
//   Rst_n asynchronous active-low reset (clears the registers and CC; the
//         instruction memory keeps its contents)
//   bus   slave side of y86_seq_fde_if
// Every decoded and execute output is combinational from PC and state.
// The register file, CC and imem change only on a clock edge.
module y86_seq_fde #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic          Clk,
    input  logic          Rst_n,
    y86_seq_fde_if.slave  bus
);
    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'h4;

    logic [7:0]  imem_q [IMEM_BYTES];
    logic [63:0] regs_q [15];
    logic        zf_q, sf_q, of_q;

    logic [7:0]  ibyte_s [10];
    logic [3:0]  icode_s, ifun_s, ra_s, rb_s, len_s;
    logic [63:0] valc_s, valp_s;
    logic        func_ok_s, mem_ok_s, valid_s;
    logic [3:0]  src_a_s, src_b_s, dst_e_s, dst_m_s;
    logic [63:0] vala_s, valb_s, alu_s, vale_s;
    logic        cnd_s, of_new_s;

    // Fetch window: up to ten bytes starting at PC. Bytes past the end of memory read as zero.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            if ((bus.PC + 64'(k)) < 64'(IMEM_BYTES)) begin
                ibyte_s[k] = imem_q[AW'(bus.PC + 64'(k))];
            end else begin
                ibyte_s[k] = 8'h00;
            end
        end
    end

    // Split the instruction into fields, find its length and check that it is legal.
    always_comb begin
        icode_s   = ibyte_s[0][7:4];
        ifun_s    = ibyte_s[0][3:0];
        ra_s      = R_NONE;
        rb_s      = R_NONE;
        valc_s    = 64'd0;
        len_s     = 4'd1;
        func_ok_s = 1'b0;
        case (icode_s)
            4'h0, 4'h1, 4'h9: begin
                len_s     = 4'd1;
                func_ok_s = (ifun_s == 4'h0);
            end
            4'h2, 4'h6, 4'hA, 4'hB: begin
                len_s = 4'd2;
                ra_s  = ibyte_s[1][7:4];
                rb_s  = ibyte_s[1][3:0];
                if (icode_s == 4'h2) begin
                    func_ok_s = (ifun_s <= 4'h6);
                end else if (icode_s == 4'h6) begin
                    func_ok_s = (ifun_s <= 4'h3);
                end else begin
                    func_ok_s = (ifun_s == 4'h0);
                end
            end
            4'h3, 4'h4, 4'h5: begin
                len_s     = 4'd10;
                ra_s      = ibyte_s[1][7:4];
                rb_s      = ibyte_s[1][3:0];
                valc_s    = {ibyte_s[9], ibyte_s[8], ibyte_s[7], ibyte_s[6],
                             ibyte_s[5], ibyte_s[4], ibyte_s[3], ibyte_s[2]};
                func_ok_s = (ifun_s == 4'h0);
            end
            4'h7, 4'h8: begin
                len_s     = 4'd9;
                valc_s    = {ibyte_s[8], ibyte_s[7], ibyte_s[6], ibyte_s[5],
                             ibyte_s[4], ibyte_s[3], ibyte_s[2], ibyte_s[1]};
                func_ok_s = (icode_s == 4'h7) ? (ifun_s <= 4'h6) : (ifun_s == 4'h0);
            end
            default: begin
                len_s     = 4'd1;
                func_ok_s = 1'b0;
            end
        endcase
        valp_s = bus.PC + 64'(len_s);
        // The sum is 65 bits wide so that a PC near 2^64 cannot wrap back into range.
        mem_ok_s = ({1'b0, bus.PC} + 65'(len_s)) <= 65'(IMEM_BYTES);
        valid_s  = func_ok_s & mem_ok_s;
    end

    // Choose the source and destination registers for this instruction.
    always_comb begin
        src_a_s = R_NONE;
        src_b_s = R_NONE;
        dst_e_s = R_NONE;
        dst_m_s = R_NONE;
        case (icode_s)
            4'h2: begin
                src_a_s = ra_s;
                dst_e_s = cnd_s ? rb_s : R_NONE;
            end
            4'h3: begin
                dst_e_s = rb_s;
            end
            4'h4: begin
                src_a_s = ra_s;
                src_b_s = rb_s;
            end
            4'h5: begin
                src_b_s = rb_s;
                dst_m_s = ra_s;
            end
            4'h6: begin
                src_a_s = ra_s;
                src_b_s = rb_s;
                dst_e_s = rb_s;
            end
            4'h8: begin
                src_b_s = R_RSP;
                dst_e_s = R_RSP;
            end
            4'h9: begin
                src_a_s = R_RSP;
                src_b_s = R_RSP;
                dst_e_s = R_RSP;
            end
            4'hA: begin
                src_a_s = ra_s;
                src_b_s = R_RSP;
                dst_e_s = R_RSP;
            end
            4'hB: begin
                src_a_s = R_RSP;
                src_b_s = R_RSP;
                dst_e_s = R_RSP;
                dst_m_s = ra_s;
            end
            default: begin
                src_a_s = R_NONE;
                src_b_s = R_NONE;
            end
        endcase
        vala_s = (src_a_s == R_NONE) ? 64'd0 : regs_q[src_a_s];
        valb_s = (src_b_s == R_NONE) ? 64'd0 : regs_q[src_b_s];
    end

    // Evaluate the branch or move condition from the registered condition codes.
    always_comb begin
        cnd_s = 1'b0;
        if (icode_s == 4'h2 || icode_s == 4'h7) begin
            case (ifun_s)
                4'h0:    cnd_s = 1'b1;
                4'h1:    cnd_s = (sf_q ^ of_q) | zf_q;
                4'h2:    cnd_s = sf_q ^ of_q;
                4'h3:    cnd_s = zf_q;
                4'h4:    cnd_s = ~zf_q;
                4'h5:    cnd_s = ~(sf_q ^ of_q);
                4'h6:    cnd_s = ~(sf_q ^ of_q) & ~zf_q;
                default: cnd_s = 1'b0;
            endcase
        end else begin
            cnd_s = 1'b0;
        end
    end

    // ALU. An illegal instruction forces valE to zero.
    always_comb begin
        alu_s    = 64'd0;
        of_new_s = 1'b0;
        case (icode_s)
            4'h2: alu_s = vala_s;
            4'h3: alu_s = valc_s;
            4'h4, 4'h5: alu_s = valb_s + valc_s;
            4'h6: begin
                case (ifun_s)
                    4'h0: begin
                        alu_s    = valb_s + vala_s;
                        of_new_s = (vala_s[63] == valb_s[63]) && (alu_s[63] != valb_s[63]);
                    end
                    4'h1: begin
                        alu_s    = valb_s - vala_s;
                        of_new_s = (vala_s[63] != valb_s[63]) && (alu_s[63] != valb_s[63]);
                    end
                    4'h2:    alu_s = valb_s & vala_s;
                    4'h3:    alu_s = valb_s ^ vala_s;
                    default: alu_s = 64'd0;
                endcase
            end
            4'h8, 4'hA: alu_s = valb_s - 64'd8;
            4'h9, 4'hB: alu_s = valb_s + 64'd8;
            default:    alu_s = 64'd0;
        endcase
        vale_s = valid_s ? alu_s : 64'd0;
    end

    // Register file writeback and CC update when the instruction is committed.
    // When both ports target the same register, the valM write is taken.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= 64'd0;
            end
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (bus.wb_en && valid_s) begin
            for (int i = 0; i < 15; i++) begin
                if (dst_m_s == 4'(i)) begin
                    regs_q[i] <= bus.valM;
                end else if (dst_e_s == 4'(i)) begin
                    regs_q[i] <= vale_s;
                end
            end
            if (icode_s == 4'h6) begin
                zf_q <= (vale_s == 64'd0);
                sf_q <= vale_s[63];
                of_q <= of_new_s;
            end
        end
    end

    // Program-load port. Writes outside the memory are dropped.
    always_ff @(posedge Clk) begin
        if (bus.imem_we && (bus.imem_addr < 64'(IMEM_BYTES))) begin
            imem_q[AW'(bus.imem_addr)] <= bus.imem_wdata;
        end
    end

    assign bus.icode       = icode_s;
    assign bus.ifun        = ifun_s;
    assign bus.rA          = ra_s;
    assign bus.rB          = rb_s;
    assign bus.valC        = valc_s;
    assign bus.valP        = valp_s;
    assign bus.instr_valid = valid_s;
    assign bus.valA        = vala_s;
    assign bus.valB        = valb_s;
    assign bus.valE        = vale_s;
    assign bus.cnd         = cnd_s;
    assign bus.ZF          = zf_q;
    assign bus.SF          = sf_q;
    assign bus.OF          = of_q;
endmodule

// File: tb/tb_y86_seq_fde.sv
// Directed testbench for y86_seq_fde. Inputs change on the falling edge.
// Outputs are sampled 1 time unit after inputs change or after a rising edge.
module tb_y86_seq_fde;
    logic Clk;
    logic Rst_n;
    int   total;
    int   bad;

    y86_seq_fde_if bus_if();

    y86_seq_fde #(.IMEM_BYTES(1024)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_if.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
        @(negedge Clk);
        bus_if.imem_we    = 1'b1;
        bus_if.imem_addr  = a;
        bus_if.imem_wdata = d;
        @(posedge Clk);
        #1;
        bus_if.imem_we = 1'b0;
    endtask

    task automatic set_pc(input logic [63:0] pc);
        @(negedge Clk);
        bus_if.PC = pc;
        #1;
    endtask

    task automatic commit();
        @(negedge Clk);
        bus_if.wb_en = 1'b1;
        @(posedge Clk);
        #1;
        bus_if.wb_en = 1'b0;
        #1;
    endtask

    // Write register r with value v by committing an irmovq placed at address 800.
    task automatic set_reg(input logic [3:0] r, input logic [63:0] v);
        load_byte(64'd800, 8'h30);
        load_byte(64'd801, {4'hF, r});
        for (int k = 0; k < 8; k++) begin
            load_byte(64'd802 + 64'(k), v[8*k +: 8]);
        end
        set_pc(64'd800);
        commit();
    endtask

    // Observe register r as valA of an rrmovq placed at address 900. Nothing is committed.
    task automatic read_reg(input logic [3:0] r, output logic [63:0] v);
        load_byte(64'd900, 8'h20);
        load_byte(64'd901, {r, 4'h0});
        set_pc(64'd900);
        v = bus_if.valA;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        Rst_n = 1'b0;
        bus_if.PC = 64'd0; bus_if.imem_we = 1'b0; bus_if.imem_addr = 64'd0;
        bus_if.imem_wdata = 8'h00; bus_if.wb_en = 1'b0; bus_if.valM = 64'd0;
        #12;
        total++;
        if ({bus_if.ZF, bus_if.SF, bus_if.OF} !== 3'b100) begin
            bad++; $display("FAIL reset_cc got=%b exp=100", {bus_if.ZF, bus_if.SF, bus_if.OF});
        end
        Rst_n = 1'b1;
        read_reg(4'h2, v);
        total++;
        if (v !== 64'd0) begin bad++; $display("FAIL reset_rdx got=%h exp=0", v); end
    endtask

    task automatic test_irmov_rrmov();
        logic [7:0] prog [12];
        prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20};
        for (int k = 0; k < 12; k++) load_byte(64'(k), prog[k]);
        set_pc(64'd0);
        total++;
        if ({bus_if.icode, bus_if.ifun, bus_if.rA, bus_if.rB} !== 16'h30F2) begin
            bad++; $display("FAIL irmov_fields got=%h exp=30f2", {bus_if.icode, bus_if.ifun, bus_if.rA, bus_if.rB});
        end
        total++;
        if (bus_if.valC !== 64'd10 || bus_if.valP !== 64'd10 || bus_if.valE !== 64'd10) begin
            bad++; $display("FAIL irmov_vals got valC=%h valP=%h valE=%h exp 10/10/10", bus_if.valC, bus_if.valP, bus_if.valE);
        end
        total++;
        if (bus_if.instr_valid !== 1'b1) begin bad++; $display("FAIL irmov_valid got=%b exp=1", bus_if.instr_valid); end
        commit();
        set_pc(64'd10);
        total++;
        if (bus_if.valA !== 64'd10 || bus_if.valP !== 64'd12 || bus_if.valC !== 64'd0) begin
            bad++; $display("FAIL rrmov got valA=%h valP=%h valC=%h exp 10/12/0", bus_if.valA, bus_if.valP, bus_if.valC);
        end
        total++;
        if (bus_if.valE !== 64'd10 || bus_if.rA !== 4'h2 || bus_if.rB !== 4'h0) begin
            bad++; $display("FAIL rrmov_e got valE=%h rA=%h rB=%h exp 10/2/0", bus_if.valE, bus_if.rA, bus_if.rB);
        end
    endtask

    task automatic test_sub();
        logic [63:0] v;
        set_reg(4'h3, 64'd3);
        load_byte(64'd20, 8'h61);
        load_byte(64'd21, 8'h32);
        set_pc(64'd20);
        total++;
        if (bus_if.valE !== 64'd7 || bus_if.valA !== 64'd3 || bus_if.valB !== 64'd10) begin
            bad++; $display("FAIL sub_vals got valE=%h valA=%h valB=%h exp 7/3/10", bus_if.valE, bus_if.valA, bus_if.valB);
        end
        commit();
        total++;
        if ({bus_if.ZF, bus_if.SF, bus_if.OF} !== 3'b000) begin
            bad++; $display("FAIL sub_cc got=%b exp=000", {bus_if.ZF, bus_if.SF, bus_if.OF});
        end
        read_reg(4'h2, v);
        total++;
        if (v !== 64'd7) begin bad++; $display("FAIL sub_rdx got=%h exp=7", v); end
    endtask

    task automatic test_add_overflow();
        set_reg(4'h0, 64'h7FFF_FFFF_FFFF_FFFF);
        set_reg(4'h1, 64'd1);
        load_byte(64'd30, 8'h60);
        load_byte(64'd31, 8'h10);
        set_pc(64'd30);
        total++;
        if (bus_if.valE !== 64'h8000_0000_0000_0000) begin
            bad++; $display("FAIL add_valE got=%h exp=8000000000000000", bus_if.valE);
        end
        commit();
        total++;
        if ({bus_if.ZF, bus_if.SF, bus_if.OF} !== 3'b011) begin
            bad++; $display("FAIL add_cc got=%b exp=011", {bus_if.ZF, bus_if.SF, bus_if.OF});
        end
    endtask

    task automatic test_cond();
        logic [63:0] v;
        logic [7:0]  jb [9];
        set_reg(4'h6, 64'd5);
        set_reg(4'h7, 64'd5);
        load_byte(64'd36, 8'h63);
        load_byte(64'd37, 8'h67);
        set_pc(64'd36);
        commit();
        total++;
        if ({bus_if.ZF, bus_if.SF, bus_if.OF} !== 3'b100) begin
            bad++; $display("FAIL xor_cc got=%b exp=100", {bus_if.ZF, bus_if.SF, bus_if.OF});
        end
        jb = '{8'h74, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 9; k++) load_byte(64'd40 + 64'(k), jb[k]);
        jb[0] = 8'h73;
        for (int k = 0; k < 9; k++) load_byte(64'd50 + 64'(k), jb[k]);
        set_pc(64'd40);
        total++;
        if (bus_if.cnd !== 1'b0 || bus_if.valC !== 64'h1234) begin
            bad++; $display("FAIL jne got cnd=%b valC=%h exp 0/1234", bus_if.cnd, bus_if.valC);
        end
        set_pc(64'd50);
        total++;
        if (bus_if.cnd !== 1'b1 || bus_if.valP !== 64'd59 || bus_if.rA !== 4'hF) begin
            bad++; $display("FAIL je got cnd=%b valP=%h rA=%h exp 1/59/f", bus_if.cnd, bus_if.valP, bus_if.rA);
        end
        // cmovne %rsi,%rbx must not write, while cmove %rsi,%rbx must.
        load_byte(64'd60, 8'h24);
        load_byte(64'd61, 8'h63);
        load_byte(64'd62, 8'h23);
        load_byte(64'd63, 8'h63);
        set_pc(64'd60);
        commit();
        read_reg(4'h3, v);
        total++;
        if (v !== 64'd3) begin bad++; $display("FAIL cmovne_rbx got=%h exp=3", v); end
        set_pc(64'd62);
        commit();
        read_reg(4'h3, v);
        total++;
        if (v !== 64'd5) begin bad++; $display("FAIL cmove_rbx got=%h exp=5", v); end
    endtask

    task automatic test_stack();
        logic [63:0] v;
        set_reg(4'h4, 64'h100);
        load_byte(64'd70, 8'hA0);
        load_byte(64'd71, 8'h4F);
        load_byte(64'd72, 8'hB0);
        load_byte(64'd73, 8'h4F);
        load_byte(64'd74, 8'h80);
        for (int k = 0; k < 8; k++) load_byte(64'd75 + 64'(k), 8'h00);
        load_byte(64'd83, 8'h90);
        set_pc(64'd70);
        total++;
        if (bus_if.valE !== 64'hF8 || bus_if.valA !== 64'h100) begin
            bad++; $display("FAIL push got valE=%h valA=%h exp f8/100", bus_if.valE, bus_if.valA);
        end
        commit();
        bus_if.valM = 64'h55;
        set_pc(64'd72);
        total++;
        if (bus_if.valE !== 64'h100) begin bad++; $display("FAIL pop_valE got=%h exp=100", bus_if.valE); end
        commit();
        read_reg(4'h4, v);
        total++;
        if (v !== 64'h55) begin bad++; $display("FAIL pop_rsp got=%h exp=55", v); end
        set_reg(4'h4, 64'h100);
        set_pc(64'd74);
        total++;
        if (bus_if.valE !== 64'hF8 || bus_if.valP !== 64'd83) begin
            bad++; $display("FAIL call got valE=%h valP=%h exp f8/53", bus_if.valE, bus_if.valP);
        end
        set_pc(64'd83);
        total++;
        if (bus_if.valE !== 64'h108 || bus_if.valP !== 64'd84) begin
            bad++; $display("FAIL ret got valE=%h valP=%h exp 108/54", bus_if.valE, bus_if.valP);
        end
    endtask

    task automatic test_invalid();
        logic [63:0] v;
        logic [7:0]  ir [10];
        load_byte(64'd100, 8'hC0);
        set_pc(64'd100);
        total++;
        if (bus_if.instr_valid !== 1'b0 || bus_if.icode !== 4'hC || bus_if.valE !== 64'd0) begin
            bad++; $display("FAIL bad_icode got valid=%b icode=%h valE=%h exp 0/c/0", bus_if.instr_valid, bus_if.icode, bus_if.valE);
        end
        commit();
        total++;
        if ({bus_if.ZF, bus_if.SF, bus_if.OF} !== 3'b100) begin
            bad++; $display("FAIL bad_icode_cc got=%b exp=100", {bus_if.ZF, bus_if.SF, bus_if.OF});
        end
        // nop with a nonzero ifun is illegal.
        load_byte(64'd101, 8'h11);
        set_pc(64'd101);
        total++;
        if (bus_if.instr_valid !== 1'b0) begin bad++; $display("FAIL nop_ifun got=%b exp=0", bus_if.instr_valid); end
        ir = '{8'h30, 8'hF2, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 5; k++) load_byte(64'd1019 + 64'(k), ir[k]);
        set_pc(64'd1019);
        total++;
        if (bus_if.instr_valid !== 1'b0 || bus_if.rB !== 4'h2 || bus_if.valP !== 64'd1029) begin
            bad++; $display("FAIL imem_edge got valid=%b rB=%h valP=%h exp 0/2/405", bus_if.instr_valid, bus_if.rB, bus_if.valP);
        end
        commit();
        read_reg(4'h2, v);
        total++;
        if (v !== 64'd7) begin bad++; $display("FAIL imem_edge_rdx got=%h exp=7", v); end
        for (int k = 0; k < 10; k++) load_byte(64'd1014 + 64'(k), ir[k]);
        set_pc(64'd1014);
        total++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.valC !== 64'h63) begin
            bad++; $display("FAIL imem_last got valid=%b valC=%h exp 1/63", bus_if.instr_valid, bus_if.valC);
        end
    endtask

    task automatic test_midrun_reset();
        logic [63:0] v;
        // rdx=7, rbx=5, so subq gives 2 and leaves ZF clear.
        set_pc(64'd20);
        commit();
        total++;
        if (bus_if.ZF !== 1'b0) begin bad++; $display("FAIL pre_reset_zf got=%b exp=0", bus_if.ZF); end
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        total++;
        if ({bus_if.ZF, bus_if.SF, bus_if.OF} !== 3'b100) begin
            bad++; $display("FAIL midrun_cc got=%b exp=100", {bus_if.ZF, bus_if.SF, bus_if.OF});
        end
        read_reg(4'h2, v);
        total++;
        if (v !== 64'd0) begin bad++; $display("FAIL midrun_rdx got=%h exp=0", v); end
        Rst_n = 1'b1;
        read_reg(4'h3, v);
        total++;
        if (v !== 64'd0) begin bad++; $display("FAIL midrun_rbx got=%h exp=0", v); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_irmov_rrmov();
        test_sub();
        test_add_overflow();
        test_cond();
        test_stack();
        test_invalid();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
